// File: rtl/ppu_oam_dma.sv
// Sprite DMA: copies one 256-byte CPU page into OAM, stalling the CPU for 513 cycles (514 with an odd-cycle align).
// No backpressure; OAM_DMA_ODD_ALIGN_EN adds the extra align cycle when cpu_odd is high.
module ppu_oam_dma (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_start,
   input  logic [7:0]  dma_page,
   input  logic [7:0]  oam_base,
   input  logic        cpu_odd,
   output logic        cpu_stall,
   output logic [15:0] mem_addr,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        oam_en,
   output logic        oam_rw,
   output logic [5:0]  spr_select,
   output logic [1:0]  byte_select,
   output logic [7:0]  oam_wdata,
   output logic        dma_busy,
   output logic        dma_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_ALIGN2 = 3'd2,
      S_READ   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] dest_q, dest_d;
   logic [7:0] page_q, page_d;

`ifndef OAM_DMA_ODD_ALIGN_EN
   logic unused_cpu_odd;
   assign unused_cpu_odd = cpu_odd;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      page_d  = page_q;
      case (state_q)
         S_IDLE: begin
            if (dma_start) begin
               page_d  = dma_page;
               dest_d  = oam_base;
               cnt_d   = 8'd0;
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
            state_d = cpu_odd ? S_ALIGN2 : S_READ;
`else
            state_d = S_READ;
`endif
         end
         S_ALIGN2: state_d = S_READ;
         S_READ:   state_d = S_WRITE;
         S_WRITE: begin
            cnt_d   = cnt_q + 8'd1;
            dest_d  = dest_q + 8'd1;
            state_d = (cnt_q == 8'hFF) ? S_DONE : S_READ;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         dest_q  <= 8'd0;
         page_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
         page_q  <= page_d;
      end
   end

   // Outputs are decoded from registered state so reset clears them without a clock edge.
   always_comb begin
      cpu_stall   = 1'b0;
      dma_busy    = 1'b0;
      mem_re      = 1'b0;
      mem_addr    = 16'h0000;
      oam_en      = 1'b0;
      oam_rw      = 1'b1;
      spr_select  = 6'd0;
      byte_select = 2'd0;
      oam_wdata   = 8'h00;
      dma_done    = 1'b0;
      case (state_q)
         S_ALIGN, S_ALIGN2: begin
            cpu_stall = 1'b1;
            dma_busy  = 1'b1;
         end
         S_READ: begin
            cpu_stall = 1'b1;
            dma_busy  = 1'b1;
            mem_re    = 1'b1;
            mem_addr  = {page_q, cnt_q};
         end
         S_WRITE: begin
            cpu_stall   = 1'b1;
            dma_busy    = 1'b1;
            oam_en      = 1'b1;
            oam_rw      = 1'b0;
            spr_select  = dest_q[7:2];
            byte_select = dest_q[1:0];
            oam_wdata   = mem_rdata;
         end
         S_DONE:  dma_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/ppu_oam_dma.md
# ppu_oam_dma

Sprite DMA engine for the PPU object attribute memory. A CPU write to $4014 starts a transfer of one 256-byte CPU page into the 64-sprite OAM. The engine stalls the CPU, alternates CPU-bus reads with OAM write strobes for 256 bytes, then releases the bus. It sits between the CPU memory arbiter and the OAM port (oam_en / oam_rw / sprite select / byte select / data), acting as the initiator on the OAM write interface.

## Interface
- No parameters.
- clk  in  1  system clock; one DMA step per cycle
- rst  in  1  reset; asynchronous, active-high
- dma_start  in  1  one-cycle pulse: CPU wrote $4014
- dma_page  in  8  source page (high address byte), sampled with dma_start
- oam_base  in  8  current OAMADDR, sampled with dma_start; first destination byte
- cpu_odd  in  1  CPU cycle parity; used only under OAM_DMA_ODD_ALIGN_EN
- cpu_stall  out  1  holds CPU off the bus while high
- mem_addr  out  16  CPU-bus read address
- mem_re  out  1  CPU-bus read strobe
- mem_rdata  in  8  read data; valid the cycle after mem_re
- oam_en  out  1  OAM access enable
- oam_rw  out  1  OAM direction: 1 = read, 0 = write; the engine drives 0 only
- spr_select  out  6  OAM sprite index = dest[7:2]
- byte_select  out  2  OAM byte within sprite = dest[1:0]
- oam_wdata  out  8  OAM write data
- dma_busy  out  1  transfer in progress
- dma_done  out  1  one-cycle pulse at completion

## Operation
- State machine with states IDLE, ALIGN, ALIGN2, READ, WRITE, DONE. The state is registered; outputs are decoded combinationally from state and the registered counters.
- IDLE:
  - dma_start=1 latches page_r=dma_page, dest_r=oam_base, cnt=0, and moves to ALIGN.
  - dma_start in any other state is ignored.
- ALIGN: dummy cycle with stall asserted and no bus activity. Next state is READ, or ALIGN2 per Configuration.
- ALIGN2: dummy cycle, then READ.
- READ: mem_re=1, mem_addr={page_r, cnt}. Next state is WRITE.
- WRITE:
  - Outputs: oam_en=1, oam_rw=0, {spr_select, byte_select}=dest_r, oam_wdata=mem_rdata (combinational pass-through).
  - Register updates: cnt+1 and dest_r+1, both mod 256. dest_r wraps 8'hFF→8'h00.
  - Next state: DONE if cnt==255 before the increment, else READ.
- DONE: dma_done=1, then IDLE.
- cpu_stall=dma_busy=1 in ALIGN, ALIGN2, READ and WRITE; both are 0 in IDLE and DONE.
- Default output values whenever not stated above: mem_re=0, oam_en=0, oam_rw=1, mem_addr=0, spr_select=0, byte_select=0, oam_wdata=0, dma_done=0.
- Exactly 256 OAM writes per transfer. Each destination byte is written once, starting at oam_base.

## Timing
- Reset (asynchronous, any state): state=IDLE, cnt=0, dest_r=0, page_r=0. All outputs take their defaults and cpu_stall=dma_busy=0 immediately, without waiting for a clock edge.
- Reset mid-transfer aborts the transfer. OAM bytes already written stay written, and no dma_done pulse is produced.
- Taking the dma_start edge as cycle 0:
  - cycle 1 is ALIGN.
  - without the extra alignment cycle, the first READ is cycle 2 and its WRITE is cycle 3.
  - the last WRITE is cycle 513 and DONE is cycle 514. cpu_stall is high for 513 cycles.
  - with the extra alignment cycle, every later event shifts by +1: 514 stall cycles, DONE at cycle 515.
- A dma_start pulse in the DONE cycle is ignored. A new transfer is accepted from the first IDLE cycle onward.

## Configuration
- OAM_DMA_ODD_ALIGN_EN defined: in ALIGN, if cpu_odd=1 the next state is ALIGN2, otherwise READ. This models the extra get-cycle on odd CPU cycles: 513 or 514 stall cycles.
- Undefined: ALIGN always goes to READ, cpu_odd is ignored, and the ALIGN2 state is unreachable (may be omitted from the RTL). Always 513 stall cycles.

## Test plan
- dma_page=8'h02, oam_base=0, source bytes [0x200+i]=i^8'h5A:
  - exactly 256 writes, the write with dest i carrying i^8'h5A.
  - cpu_stall high for 513 cycles, dma_done pulse at cycle 514.
- oam_base=8'hFC, page 8'h03:
  - first write goes to spr_select=63, byte_select=0 with data [0x300].
  - the 5th write goes to sprite 0 byte 0 with data [0x304] (wrap).
  - the last write goes to dest 8'hFB.
- With OAM_DMA_ODD_ALIGN_EN and cpu_odd=1 at ALIGN: stall lasts 514 cycles and the first mem_re appears at cycle 3. With cpu_odd=0: 513 cycles.
- dma_start pulsed again at cycles 10 and 514 of an active transfer: no restart, no page change, and exactly one dma_done pulse.
- rst asserted at cycle 100:
  - cpu_stall, dma_busy and oam_en drop immediately, and no dma_done pulse occurs.
  - a later dma_start runs a complete 256-byte transfer.
- oam_rw stays 1 whenever oam_en=0. No cycle has mem_re=1 and oam_en=1 together.
